// File: rtl/tag_allocator.sv
// Physical-tag free list feeding rename: up to NUM_ISSUE grants per cycle, commit release, mispredict rollback.
// Optional macro TAGALLOC_ERR_EN adds a sticky OUT_err for double-free / unallocated-commit detection.
module tag_allocator #(
  parameter int unsigned NUM_ISSUE  = 4,
  parameter int unsigned NUM_COMMIT = 4,
  parameter int unsigned TAG_SIZE   = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  IN_mispred,
  input  logic                                  IN_mispredFlush,
  input  logic [NUM_ISSUE-1:0]                  IN_allocValid,
  output logic [NUM_ISSUE-1:0][TAG_SIZE-1:0]    OUT_allocTag,
  output logic                                  OUT_stall,
  input  logic [NUM_COMMIT-1:0]                 IN_commitValid,
  input  logic [NUM_COMMIT-1:0][TAG_SIZE-1:0]   IN_commitTag,
  input  logic [NUM_COMMIT-1:0][TAG_SIZE-1:0]   IN_commitPrevTag,
  output logic [TAG_SIZE-1:0]                   OUT_freeCount
`ifdef TAGALLOC_ERR_EN
  ,
  output logic                                  OUT_err
`endif
);

  localparam int unsigned IDX_W    = TAG_SIZE - 1;
  localparam int unsigned NUM_TAGS = 1 << IDX_W;
  localparam int unsigned CNT_W    = $clog2(NUM_ISSUE + 1);
  localparam int unsigned ISSUE_W  = (NUM_ISSUE > 1) ? $clog2(NUM_ISSUE) : 1;
  localparam logic [TAG_SIZE-1:0] NO_TAG = {1'b1, {IDX_W{1'b0}}};

  logic [NUM_TAGS-1:0]               r_specUsed;
  logic [NUM_TAGS-1:0]               r_comUsed;
  logic [TAG_SIZE-1:0]               r_freeCount;

  logic [NUM_ISSUE-1:0][IDX_W-1:0]   w_freeIdx;
  logic [CNT_W-1:0]                  w_rank;
  logic [CNT_W-1:0]                  w_slot;
  logic [TAG_SIZE-1:0]               w_reqCount;
  logic                              w_stall;
  logic [NUM_TAGS-1:0]               w_grantMask;
  logic [NUM_TAGS-1:0]               w_comSet;
  logic [NUM_TAGS-1:0]               w_relClr;
  logic [NUM_TAGS-1:0]               w_flushSet;
  logic [NUM_TAGS-1:0]               w_comNext;
  logic [NUM_TAGS-1:0]               w_specNext;
  logic [TAG_SIZE-1:0]               w_freeNext;

  // Lowest NUM_ISSUE free indices, in ascending order
  always_comb begin
    w_freeIdx = '0;
    w_rank    = '0;
    for (int j = 0; j < int'(NUM_TAGS); j++) begin
      if (!r_specUsed[j]) begin
        for (int r = 0; r < int'(NUM_ISSUE); r++) begin
          if (w_rank == CNT_W'(r)) w_freeIdx[r] = IDX_W'(j);
        end
        if (w_rank != CNT_W'(NUM_ISSUE)) w_rank = w_rank + 1'b1;
      end
    end
  end

  assign w_reqCount = TAG_SIZE'($countones(IN_allocValid));
  assign w_stall    = !rst || IN_mispred || (w_reqCount > r_freeCount);

  // Valid port i takes the free index ranked by the number of valid ports below it
  always_comb begin
    OUT_allocTag = {NUM_ISSUE{NO_TAG}};
    w_grantMask  = '0;
    w_slot       = '0;
    for (int i = 0; i < int'(NUM_ISSUE); i++) begin
      if (IN_allocValid[i] && !w_stall) begin
        OUT_allocTag[i] = {1'b0, w_freeIdx[w_slot[ISSUE_W-1:0]]};
        w_grantMask[w_freeIdx[w_slot[ISSUE_W-1:0]]] = 1'b1;
      end
      if (IN_allocValid[i]) w_slot = w_slot + 1'b1;
    end
  end

  always_comb begin
    w_comSet   = '0;
    w_relClr   = '0;
    w_flushSet = '0;
    for (int c = 0; c < int'(NUM_COMMIT); c++) begin
      if (IN_commitValid[c]) begin
        if (!IN_mispredFlush) begin
          if (!IN_commitTag[c][IDX_W])     w_comSet[IN_commitTag[c][IDX_W-1:0]]     = 1'b1;
          if (!IN_commitPrevTag[c][IDX_W]) w_relClr[IN_commitPrevTag[c][IDX_W-1:0]] = 1'b1;
        end else if (!IN_mispred && !IN_commitTag[c][IDX_W]) begin
          w_flushSet[IN_commitTag[c][IDX_W-1:0]] = 1'b1;
        end
      end
    end
  end

  // Releases win over same-cycle sets; mispredict restores the committed view
  assign w_comNext  = (r_comUsed | w_comSet) & ~w_relClr;
  assign w_specNext = IN_mispred ? w_comNext
                                 : ((r_specUsed | w_grantMask | w_flushSet) & ~w_relClr);
  assign w_freeNext = TAG_SIZE'(NUM_TAGS - $countones(w_specNext));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_specUsed  <= '0;
      r_comUsed   <= '0;
      r_freeCount <= TAG_SIZE'(NUM_TAGS);
    end else begin
      r_specUsed  <= w_specNext;
      r_comUsed   <= w_comNext;
      r_freeCount <= w_freeNext;
    end
  end

  assign OUT_stall     = w_stall;
  assign OUT_freeCount = r_freeCount;

`ifdef TAGALLOC_ERR_EN
  logic r_err;
  logic w_errHit;

  // Releasing an uncommitted tag, or committing a tag never allocated
  always_comb begin
    w_errHit = 1'b0;
    for (int c = 0; c < int'(NUM_COMMIT); c++) begin
      if (IN_commitValid[c] && !IN_mispredFlush) begin
        if (!IN_commitTag[c][IDX_W] && !r_specUsed[IN_commitTag[c][IDX_W-1:0]])
          w_errHit = 1'b1;
        if (!IN_commitPrevTag[c][IDX_W] && !r_comUsed[IN_commitPrevTag[c][IDX_W-1:0]])
          w_errHit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= r_err | w_errHit;
  end

  assign OUT_err = r_err;
`endif

endmodule

// File: tb/tb_tag_allocator.sv
// Scoreboard bench for tag_allocator: driver queues expected outputs, negedge monitor compares.
module tb_tag_allocator;

  localparam logic [6:0] INV = 7'h40;

  typedef struct {
    string            nm;
    bit               cs;
    bit               s;
    logic [3:0]       ctm;
    logic [3:0][6:0]  t;
    bit               cf;
    logic [6:0]       f;
    bit               ce;
    bit               e;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mispred = 1'b0;
  logic            flush = 1'b0;
  logic [3:0]      av = '0;
  logic [3:0]      cv = '0;
  logic [3:0][6:0] ct = {4{INV}};
  logic [3:0][6:0] cp = {4{INV}};
  logic [3:0][6:0] tags;
  logic            stall;
  logic [6:0]      fc;
  logic            err;

  tag_allocator dut (
    .clk              (clk),
    .rst              (rst_n),
    .IN_mispred       (mispred),
    .IN_mispredFlush  (flush),
    .IN_allocValid    (av),
    .OUT_allocTag     (tags),
    .OUT_stall        (stall),
    .IN_commitValid   (cv),
    .IN_commitTag     (ct),
    .IN_commitPrevTag (cp),
    .OUT_freeCount    (fc)
`ifdef TAGALLOC_ERR_EN
    ,
    .OUT_err          (err)
`endif
  );

`ifndef TAGALLOC_ERR_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [3:0][6:0] t4(input logic [6:0] a, input logic [6:0] b,
                                         input logic [6:0] c, input logic [6:0] d);
    t4[0] = a; t4[1] = b; t4[2] = c; t4[3] = d;
  endfunction

  task automatic ex(input string nm, input bit cs, input bit s, input logic [3:0] ctm,
                    input logic [3:0][6:0] t, input bit cf, input logic [6:0] f);
    exp_t x;
    x.nm = nm; x.cs = cs; x.s = s; x.ctm = ctm; x.t = t; x.cf = cf; x.f = f;
    x.ce = 1'b0; x.e = 1'b0;
    q.push_back(x);
  endtask

  task automatic exe(input string nm, input bit e);
    exp_t x;
    x.nm = nm; x.cs = 1'b0; x.s = 1'b0; x.ctm = '0; x.t = '0; x.cf = 1'b0; x.f = '0;
    x.ce = 1'b1; x.e = e;
    q.push_back(x);
  endtask

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    av = '0; cv = '0; ct = {4{INV}}; cp = {4{INV}}; mispred = 1'b0; flush = 1'b0;
  endtask

  // Monitor: pops whatever the driver queued for this cycle
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        x = q.pop_front();
        if (x.cs) cmp(x.nm, "stall", 32'(stall), 32'(x.s));
        for (int p = 0; p < 4; p++)
          if (x.ctm[p]) cmp(x.nm, $sformatf("tag%0d", p), 32'(tags[p]), 32'(x.t[p]));
        if (x.cf) cmp(x.nm, "freeCount", 32'(fc), 32'(x.f));
        if (x.ce) cmp(x.nm, "err", 32'(err), 32'(x.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tick();
    av = 4'hF; ex("reset", 1, 1, 4'hF, t4(INV, INV, INV, INV), 1, 7'd64); exe("reset_err", 0); tick();
    rst_n = 1'b1;
    av = 4'hF; ex("alloc4", 1, 0, 4'hF, t4(7'd0, 7'd1, 7'd2, 7'd3), 1, 7'd64); tick();
    ex("fc_after4", 0, 0, 4'h0, t4(INV, INV, INV, INV), 1, 7'd60); tick();

    rst_n = 1'b0; tick(); rst_n = 1'b1;
    av = 4'b0101; ex("sparse", 1, 0, 4'hF, t4(7'd0, INV, 7'd1, INV), 1, 7'd64); tick();
    for (int n = 0; n < 15; n++) begin
      av = 4'hF;
      ex($sformatf("fill%0d", n), 1, 0, 4'hF,
         t4(7'(2 + 4*n), 7'(3 + 4*n), 7'(4 + 4*n), 7'(5 + 4*n)), 1, 7'(62 - 4*n));
      tick();
    end
    av = 4'hF;    ex("over", 1, 1, 4'hF, t4(INV, INV, INV, INV), 1, 7'd2); tick();
    av = 4'b0011; ex("last2", 1, 0, 4'hF, t4(7'd62, 7'd63, INV, INV), 1, 7'd2); tick();
    av = 4'b1000; ex("full", 1, 1, 4'hF, t4(INV, INV, INV, INV), 1, 7'd0); tick();

    cv = 4'b0001; ct[0] = 7'd5; cp[0] = INV;
    ex("commit_msb_prev", 0, 0, 4'h0, t4(INV, INV, INV, INV), 1, 7'd0); tick();
    cv = 4'b0001; ct[0] = 7'd6; cp[0] = 7'd5;
    ex("no_free_yet", 0, 0, 4'h0, t4(INV, INV, INV, INV), 1, 7'd0); tick();
    av = 4'b1000; ex("reuse5", 1, 0, 4'hF, t4(INV, INV, INV, 7'd5), 1, 7'd1); tick();
    ex("refull", 0, 0, 4'h0, t4(INV, INV, INV, INV), 1, 7'd0); tick();

    rst_n = 1'b0; av = 4'hF;
    ex("reset2", 1, 1, 4'hF, t4(INV, INV, INV, INV), 0, 7'd0); tick();
    rst_n = 1'b1;
    av = 4'hF; ex("a0_3", 1, 0, 4'hF, t4(7'd0, 7'd1, 7'd2, 7'd3), 1, 7'd64); tick();
    av = 4'hF; ex("a4_7", 1, 0, 4'hF, t4(7'd4, 7'd5, 7'd6, 7'd7), 1, 7'd60); tick();
    cv = 4'hF; ct = t4(7'd0, 7'd1, 7'd2, 7'd3);
    ex("commit0_3", 0, 0, 4'h0, t4(INV, INV, INV, INV), 1, 7'd56); tick();
    mispred = 1'b1; av = 4'hF;
    ex("mispred", 1, 1, 4'hF, t4(INV, INV, INV, INV), 1, 7'd56); tick();
    flush = 1'b1; cv = 4'b0001; ct[0] = 7'd4;
    ex("rollback", 0, 0, 4'h0, t4(INV, INV, INV, INV), 1, 7'd60); tick();
    av = 4'b0001; ex("after_replay", 1, 0, 4'hF, t4(7'd5, INV, INV, INV), 1, 7'd59); tick();
    av = 4'hF; ex("refill", 1, 0, 4'hF, t4(7'd6, 7'd7, 7'd8, 7'd9), 1, 7'd58); tick();
    ex("fc54", 0, 0, 4'h0, t4(INV, INV, INV, INV), 1, 7'd54);
`ifdef TAGALLOC_ERR_EN
    exe("err_clean", 0); cv = 4'b0001; ct[0] = INV; cp[0] = 7'd9;
`endif
    tick();
`ifdef TAGALLOC_ERR_EN
    exe("err_set", 1); tick();
    exe("err_sticky", 1); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exe("err_cleared", 0); tick();
`endif

    repeat (2) @(negedge clk);
    cmp("drain", "queue", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tag_allocator.md
Name: tag_allocator

Overview:
- Physical-tag free list directly upstream of the rename table; supplies the tags rename writes into the speculative map.
- Grants up to NUM_ISSUE fresh tags per cycle.
- Commit releases each instruction's previous tag, as reported by the rename table's commit lookup.
- Mispredict rolls speculative allocations back to the committed set; the ROB then replays surviving in-flight tags.

Parameters:
- NUM_ISSUE, 4, allocation ports per cycle
- NUM_COMMIT, 4, commit/release ports per cycle
- TAG_SIZE, 7, tag width; MSB set = non-register (immediate/zero) tag, never allocated or freed
- NUM_TAGS, 1<<(TAG_SIZE-1), allocatable tags (localparam)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- IN_mispred  in  1  mispredict: roll back speculative state
- IN_mispredFlush  in  1  commit ports carry replayed (non-retiring) ops
- IN_allocValid  in  NUM_ISSUE x1  port i requests a tag
- OUT_allocTag  out  NUM_ISSUE x TAG_SIZE  granted tag; MSB=0 when granted
- OUT_stall  out  1  insufficient free tags; no grant this cycle
- IN_commitValid  in  NUM_COMMIT x1  commit slot valid
- IN_commitTag  in  NUM_COMMIT x TAG_SIZE  committing op's own tag
- IN_commitPrevTag  in  NUM_COMMIT x TAG_SIZE  tag it displaced (from rename table)
- OUT_freeCount  out  TAG_SIZE  registered count of spec-free tags

Behaviour:
- State: specUsed[NUM_TAGS] and comUsed[NUM_TAGS] bitmaps; freeCount register.
- Reset (rst=0 at clk edge): both bitmaps cleared, freeCount=NUM_TAGS.
  - While rst=0: OUT_stall=1, OUT_allocTag[i]={1'b1,0}.
- Allocation (combinational from registered state, 0-cycle latency):
  - Port i takes the k-th lowest free index in specUsed, where k = number of valid ports below i.
  - Invalid ports output {1'b1,0}.
- OUT_stall=1 iff popcount(IN_allocValid) > freeCount, or IN_mispred=1.
  - All-or-nothing: when stalled, no tag is marked used.
  - Tags freed in the same cycle are not grantable until the next cycle.
- Grant (not stalled): granted tags set in specUsed next edge.
- Normal commit (IN_commitValid, IN_mispredFlush=0):
  - Set comUsed[commitTag] if its MSB=0.
  - Clear comUsed and specUsed at prevTag if its MSB=0.
- Flush commit (IN_mispredFlush=1, IN_mispred=0): set specUsed[commitTag] if MSB=0 (replay); comUsed unchanged.
- IN_mispred=1:
  - specUsed <= comUsed with this cycle's normal-commit updates applied.
  - Allocation suppressed.
  - Flush commits ignored.
- Same-cycle set and clear of one index: clear (free) wins.
- freeCount <= NUM_TAGS - popcount(next specUsed); always consistent with the bitmap.
- Full (freeCount=0): any request stalls.
- Empty-used: all NUM_TAGS allocatable.

Optional Feature:
- Macro: TAGALLOC_ERR_EN.
- Defined: adds output OUT_err (1 bit), sticky, reset to 0. Set on either:
  - freeing a prevTag whose comUsed bit is already 0, or
  - a commitTag whose specUsed bit is 0 on a normal commit.
- Undefined: port and checks absent; behaviour otherwise identical.

Test Plan:
- Reset then 4 requests → tags 0,1,2,3 granted, OUT_stall=0, next cycle OUT_freeCount=60.
- Requests on ports 0 and 2 only → port0=0, port2=1, port1/port3={1'b1,0}.
- Allocate 62 tags, then request 4 → OUT_stall=1, freeCount stays 2; request 2 → tags 62,63 granted.
- Commit tag 5 with prevTag 0x40 (MSB set) → no free; commit tag 6 with prevTag 5 → tag 5 free next cycle, freeCount +1.
- Allocate 0–7, commit 0–3, assert IN_mispred → freeCount=60, tags 4–7 free; flush-commit tag 4 → tag 4 used again, next grant returns 5.
- With TAGALLOC_ERR_EN: commit prevTag 9 never allocated → OUT_err=1 and stays 1 until reset.
